// File: rtl/irq_gateway.sv
// Interrupt gateway: per-source level/edge capture, two-context priority
// arbitration with claim/complete handshake and registered external IRQ lines.
module irq_gateway #(
    parameter int NSRC  = 7,
    parameter int PRIOW = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] Src,
    input  logic            RegRead,
    input  logic            RegWrite,
    input  logic [2:0]      RegAddr,
    input  logic [31:0]     RegWData,
    output logic [31:0]     RegRData,
    output logic            MExtInt,
    output logic            SExtInt
);

    localparam int PW = NSRC * PRIOW;

    logic [NSRC-1:0]  sync1, sync2, sync_prev;
    logic [NSRC-1:0]  pending, inflight;
    logic [PW-1:0]    prio;
    logic [NSRC-1:0]  trig, enm, ens;
    logic [PRIOW-1:0] thrm, thrs;

    logic             rd, wr, is_claim;
    logic [3:0]       claim_id;
    logic [NSRC-1:0]  clr, cpl, rise, inflight_eff, set, gtm, gts;
    logic [31:0]      rdata;

    function automatic logic [3:0] pick(input logic [NSRC-1:0] cand,
                                        input logic [PW-1:0] pr);
        logic [PRIOW-1:0] best;
        logic [3:0]       id;
        best = '0;
        id   = '0;
        // Strict compare keeps the lowest ID on ties and skips priority 0.
        for (int i = 0; i < NSRC; i++) begin
            if (cand[i] && pr[i*PRIOW +: PRIOW] > best) begin
                best = pr[i*PRIOW +: PRIOW];
                id   = 4'(i + 1);
            end
        end
        return id;
    endfunction

    assign rd       = RegRead;
    assign wr       = RegWrite & ~RegRead;
    assign is_claim = RegAddr[2:1] == 2'b11;
    assign rise     = sync2 & ~sync_prev;

    always_comb begin
        claim_id = RegAddr[0] ? pick(pending & ens, prio)
                              : pick(pending & enm, prio);
        for (int i = 0; i < NSRC; i++) begin
            clr[i] = rd && is_claim && claim_id == 4'(i + 1);
            cpl[i] = wr && is_claim && RegWData == 32'(i + 1);
            gtm[i] = prio[i*PRIOW +: PRIOW] > thrm;
            gts[i] = prio[i*PRIOW +: PRIOW] > thrs;
        end
        // A completion this cycle lets a still-high level source re-arm at once.
        inflight_eff = inflight & ~cpl;
        set = (trig & rise) | (~trig & sync2 & ~inflight_eff & ~pending);
    end

    always_comb begin
        rdata = '0;
        case (RegAddr)
            3'd0:    rdata = 32'(prio);
            3'd1:    rdata = 32'(trig);
            3'd2:    rdata = 32'(enm);
            3'd3:    rdata = 32'(ens);
            3'd4:    rdata = 32'(thrm);
            3'd5:    rdata = 32'(thrs);
            default: rdata = 32'(claim_id);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            sync_prev <= '0;
            pending   <= '0;
            inflight  <= '0;
            prio      <= '0;
            trig      <= '0;
            enm       <= '0;
            ens       <= '0;
            thrm      <= '0;
            thrs      <= '0;
            RegRData  <= '0;
            MExtInt   <= 1'b0;
            SExtInt   <= 1'b0;
        end else begin
            sync1     <= Src;
            sync2     <= sync1;
            sync_prev <= sync2;
            pending   <= (pending & ~clr) | set;
            inflight  <= inflight_eff | clr;
            MExtInt   <= |(pending & enm & gtm);
            SExtInt   <= |(pending & ens & gts);
            if (rd) begin
                RegRData <= rdata;
            end
            if (wr) begin
                case (RegAddr)
                    3'd0:    prio <= RegWData[PW-1:0];
                    3'd1:    trig <= RegWData[NSRC-1:0];
                    3'd2:    enm  <= RegWData[NSRC-1:0];
                    3'd3:    ens  <= RegWData[NSRC-1:0];
                    3'd4:    thrm <= RegWData[PRIOW-1:0];
                    3'd5:    thrs <= RegWData[PRIOW-1:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_irq_gateway.sv
// Directed bench for irq_gateway; read data checked through an
// expected-value queue, outputs sampled 1ns after the rising edge.
module tb_irq_gateway;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  Src;
    logic        RegRead, RegWrite;
    logic [2:0]  RegAddr;
    logic [31:0] RegWData;
    logic [31:0] RegRData;
    logic        MExtInt, SExtInt;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    irq_gateway #(.NSRC(7), .PRIOW(3)) dut (
        .clk(clk), .reset(reset), .Src(Src),
        .RegRead(RegRead), .RegWrite(RegWrite), .RegAddr(RegAddr),
        .RegWData(RegWData), .RegRData(RegRData),
        .MExtInt(MExtInt), .SExtInt(SExtInt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        RegWrite = 1'b1;
        RegAddr  = a;
        RegWData = d;
        tick();
        RegWrite = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a,
                      input logic [31:0] e);
        exp_q.push_back(e);
        RegRead = 1'b1;
        RegAddr = a;
        tick();
        RegRead = 1'b0;
        chk(tag, RegRData, exp_q.pop_front());
    endtask

    task automatic do_reset();
        Src   = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic pulse1(input int low_after);
        Src[0] = 1'b1;
        tick(2);
        Src[0] = 1'b0;
        tick(low_after);
    endtask

    initial begin
        reset = 1'b1;
        Src = '0;
        RegRead = 1'b0;
        RegWrite = 1'b0;
        RegAddr = '0;
        RegWData = '0;
        tick();
        chk("rst_rdata", RegRData, 32'h0);
        chk("rst_mext", 32'(MExtInt), 32'h0);
        chk("rst_sext", 32'(SExtInt), 32'h0);
        reset = 1'b0;
        tick();

        // Level source 3
        wr(3'd0, 32'h80);
        wr(3'd2, 32'h04);
        wr(3'd4, 32'h1);
        rd("lvl_prio_rd", 3'd0, 32'h80);
        rd("lvl_enm_rd", 3'd2, 32'h04);
        Src = 7'b0000100;
        tick(3);
        chk("lvl_mext_c3", 32'(MExtInt), 32'h0);
        tick();
        chk("lvl_mext_c4", 32'(MExtInt), 32'h1);
        rd("lvl_claim", 3'd6, 32'd3);
        chk("lvl_mext_r1", 32'(MExtInt), 32'h1);
        tick();
        chk("lvl_mext_r2", 32'(MExtInt), 32'h0);
        tick(3);
        chk("lvl_rdata_hold", RegRData, 32'd3);
        chk("lvl_no_reassert", 32'(MExtInt), 32'h0);
        rd("lvl_claim_empty", 3'd6, 32'd0);
        wr(3'd6, 32'd8);
        wr(3'd6, 32'h103);
        tick(2);
        chk("lvl_bad_complete", 32'(MExtInt), 32'h0);
        wr(3'd6, 32'd3);
        chk("lvl_cpl_w1", 32'(MExtInt), 32'h0);
        tick();
        chk("lvl_cpl_w2", 32'(MExtInt), 32'h1);

        // Read wins over simultaneous write
        RegRead = 1'b1;
        RegWrite = 1'b1;
        RegAddr = 3'd4;
        RegWData = 32'h7;
        exp_q.push_back(32'h1);
        tick();
        RegRead = 1'b0;
        RegWrite = 1'b0;
        chk("rdwr_rdata", RegRData, exp_q.pop_front());
        rd("rdwr_thrm", 3'd4, 32'h1);

        // Unimplemented bits
        wr(3'd0, 32'hFFFF_FFFF);
        rd("mask_prio", 3'd0, 32'h1F_FFFF);
        wr(3'd1, 32'hFFFF_FFFF);
        rd("mask_edge", 3'd1, 32'h7F);
        wr(3'd5, 32'hFFFF_FFFF);
        rd("mask_thrs", 3'd5, 32'h7);

        // Priority
        do_reset();
        wr(3'd0, 32'h4020);
        wr(3'd2, 32'h12);
        Src = 7'b0010010;
        tick(4);
        rd("prio_tie", 3'd6, 32'd2);
        wr(3'd0, 32'h6020);
        rd("prio_hi", 3'd6, 32'd5);
        rd("prio_none", 3'd6, 32'd0);

        // Threshold
        do_reset();
        wr(3'd0, 32'h10);
        wr(3'd2, 32'h02);
        wr(3'd4, 32'h2);
        Src = 7'b0000010;
        tick(5);
        chk("thr_mext", 32'(MExtInt), 32'h0);
        rd("thr_claim", 3'd6, 32'd2);

        // Edge source 1
        do_reset();
        wr(3'd0, 32'h1);
        wr(3'd1, 32'h1);
        wr(3'd2, 32'h1);
        pulse1(4);
        chk("edge_mext", 32'(MExtInt), 32'h1);
        rd("edge_claim1", 3'd6, 32'd1);
        pulse1(2);
        pulse1(3);
        rd("edge_claim2", 3'd6, 32'd1);
        rd("edge_claim3", 3'd6, 32'd0);
        wr(3'd6, 32'd1);
        pulse1(4);
        tick(2);
        Src[0] = 1'b1;
        tick(2);
        rd("edge_race_claim", 3'd6, 32'd1);
        Src[0] = 1'b0;
        rd("edge_race_kept", 3'd6, 32'd1);
        rd("edge_race_empty", 3'd6, 32'd0);

        // Context split
        do_reset();
        wr(3'd3, 32'h02);
        wr(3'd0, 32'h08);
        Src = 7'b0000010;
        tick(4);
        chk("ctx_sext", 32'(SExtInt), 32'h1);
        chk("ctx_mext", 32'(MExtInt), 32'h0);
        rd("ctx_claimm", 3'd6, 32'd0);
        rd("ctx_claims", 3'd7, 32'd2);

        // Reset mid-operation
        do_reset();
        wr(3'd0, 32'h8200);
        wr(3'd1, 32'h40);
        wr(3'd2, 32'h28);
        wr(3'd3, 32'h01);
        wr(3'd5, 32'h1);
        Src = 7'b0101000;
        tick(4);
        rd("mid_claim", 3'd6, 32'd4);
        tick();
        chk("mid_mext_pre", 32'(MExtInt), 32'h1);
        Src = '0;
        reset = 1'b1;
        #2;
        chk("mid_async_mext", 32'(MExtInt), 32'h0);
        chk("mid_async_rdata", RegRData, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        for (int a = 0; a < 6; a++) begin
            rd("mid_reg_zero", 3'(a), 32'h0);
        end
        rd("mid_claimm", 3'd6, 32'd0);
        rd("mid_claims", 3'd7, 32'd0);
        chk("mid_sext", 32'(SExtInt), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/irq_gateway.md
IRQ_GATEWAY -- requirements
Module: irq_gateway

Interface
REQ-001 Parameter NSRC, default 7: number of interrupt sources, IDs 1..NSRC; ID 0 means "no interrupt"; NSRC <= 10.
REQ-002 Parameter PRIOW, default 3: priority width; priority 0 means never interrupts.
REQ-003 clk  in  1  the single clock.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 Src  in  NSRC  asynchronous interrupt request lines; bit i-1 is source i.
REQ-006 RegRead  in  1  register read strobe.
REQ-007 RegWrite  in  1  register write strobe.
REQ-008 RegAddr  in  3  word address of the register.
REQ-009 RegWData  in  32  write data.
REQ-010 RegRData  out  32  read data, registered, valid the cycle after RegRead.
REQ-011 MExtInt  out  1  machine external interrupt pending; drives MIP bit 11.
REQ-012 SExtInt  out  1  supervisor external interrupt pending; drives MIP bit 9.

Function
REQ-013 Register map (RegAddr):
- 0 PRIO: priority of source i in bits [PRIOW*i-1 : PRIOW*(i-1)].
- 1 EDGE: bit i-1 = 1 makes source i edge-triggered, else level-triggered.
- 2 ENM: machine-context enables.
- 3 ENS: supervisor-context enables.
- 4 THRM: machine threshold in bits [PRIOW-1:0].
- 5 THRS: supervisor threshold in bits [PRIOW-1:0].
- 6 CLAIMM: machine claim/complete.
- 7 CLAIMS: supervisor claim/complete.
REQ-014 Reads of registers 0-5 return the stored value, zero-extended; unimplemented bits write-ignored and read 0.
REQ-015 Configuration writes take effect the cycle after the write.
REQ-016 Synchronization: each Src bit passes through a 2-flop synchronizer (SrcS); edge detection compares SrcS with its previous value.
REQ-017 Level gateway: pending[i] is set when SrcS[i]=1, inflight[i]=0 and pending[i]=0.
REQ-018 Edge gateway: pending[i] is set on a SrcS rising edge regardless of inflight; further edges while pending is set are dropped.
REQ-019 Latency: a Src assertion sets pending 3 cycles later; MExtInt/SExtInt respond 1 cycle after that.
REQ-020 MExtInt is registered: next value is 1 if any i has pending & ENM & (PRIO > THRM); SExtInt is the same using ENS and THRS.
REQ-021 Claim: a read of CLAIMx returns the ID of the highest-priority pending source enabled in context x with PRIO != 0.
- Threshold is ignored for claims.
- Priority ties resolve to the lowest ID.
- Returns 0 if no source qualifies.
REQ-022 On a claim with nonzero ID, in the same cycle: pending[ID] is cleared and inflight[ID] is set.
REQ-023 A claim and a new edge on the same source in the same cycle leave pending=1 and inflight=1.
REQ-024 Complete: a write of ID to CLAIMx clears inflight[ID] if 1 <= ID <= NSRC; any other value is ignored.
REQ-025 If RegRead and RegWrite are asserted together, the read is performed and the write is ignored.
REQ-026 When RegRead=0, RegRData holds its previous value.

Reset
REQ-027 On reset, the following clear to 0 immediately:
- synchronizers, pending, inflight;
- PRIO, EDGE, ENM, ENS, THRM, THRS;
- RegRData, MExtInt, SExtInt.
REQ-028 Reset asserted mid-operation discards all pending and in-flight state; the first claim after reset returns 0.

Verification
REQ-029 Level: PRIO3=2, ENM=0x04, THRM=1, Src[2] rises at cycle 0 ->
- MExtInt=1 at cycle 4.
- Read CLAIMM -> RegRData=3; MExtInt=0 two cycles after the read.
- Src held high with no complete -> no re-assert.
- Write CLAIMM=3 -> MExtInt=1 again 2 cycles later.
REQ-030 Priority: sources 2 and 5 pending, both PRIO=4, enabled -> claim returns 2; then set PRIO5=6 -> next claim returns 5.
REQ-031 Threshold: PRIO2=2, THRM=2, source 2 pending -> MExtInt stays 0; CLAIMM still returns 2.
REQ-032 Edge: EDGE bit 0 set, source 1 claimed (in flight), two more pulses arrive ->
- Next claim returns 1.
- The following claim returns 0.
REQ-033 Context split: ENS=0x02, ENM=0, THRS=0, PRIO2=1, source 2 asserted -> SExtInt=1, MExtInt=0; CLAIMM returns 0; CLAIMS returns 2.
REQ-034 Reset mid-operation: source 4 in flight and source 6 pending, then reset pulse -> outputs 0, all registers read 0, claims return 0.
